// File: rtl/gift128_enc_iterative.sv
// Iterative GIFT-128 encryption core. Round keys and round constants are derived
// on the fly; ROUNDS_PER_CYCLE chained rounds are evaluated per clock.
module gift128_enc_iterative #(
   parameter int ROUNDS           = 40,
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         inClk,
   input  logic         inRst,
   input  logic         inValid,
   output logic         outReady,
   input  logic [127:0] inData,
   input  logic [127:0] inKey,
   output logic         outValid,
   input  logic         inReady,
   output logic [127:0] outData
);
   localparam int CW = $clog2(ROUNDS + 1);

   if (ROUNDS != 40 ||
       !(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
         ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 10) ||
       (ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("gift128_enc_iterative: unsupported ROUNDS/ROUNDS_PER_CYCLE combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   function automatic int perm_idx(input int i);
      return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
   endfunction

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h1;  4'h1: y = 4'ha;  4'h2: y = 4'h4;  4'h3: y = 4'hc;
         4'h4: y = 4'h6;  4'h5: y = 4'hf;  4'h6: y = 4'h3;  4'h7: y = 4'h9;
         4'h8: y = 4'h2;  4'h9: y = 4'hd;  4'ha: y = 4'hb;  4'hb: y = 4'h7;
         4'hc: y = 4'h5;  4'hd: y = 4'h0;  4'he: y = 4'h8;  default: y = 4'he;
      endcase
      return y;
   endfunction

   function automatic logic [5:0] const_upd(input logic [5:0] c);
      return {c[4:0], c[5] ^ c[4] ^ 1'b1};
   endfunction

   // k7..k2 shift down two words; k1 and k0 are rotated right into k7 and k6.
   function automatic logic [127:0] key_upd(input logic [127:0] k);
      return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
   endfunction

   state_t          r_state;
   state_t          w_state_next;
   logic [127:0]    r_st;
   logic [127:0]    r_key;
   logic [5:0]      r_c;
   logic [CW-1:0]   r_cnt;
   logic [127:0]    r_out_data;
   logic            w_last;

   logic [127:0]    w_st  [ROUNDS_PER_CYCLE+1];
   logic [127:0]    w_key [ROUNDS_PER_CYCLE+1];
   logic [5:0]      w_c   [ROUNDS_PER_CYCLE+1];

   assign w_st[0]  = r_st;
   assign w_key[0] = r_key;
   assign w_c[0]   = r_c;

   for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
      logic [127:0] w_sub;
      logic [127:0] w_perm;
      logic [127:0] w_rk;

      assign w_c[gi+1] = const_upd(w_c[gi]);

      for (genvar gj = 0; gj < 32; gj++) begin : g_nib
         assign w_sub[4*gj +: 4] = sbox(w_st[gi][4*gj +: 4]);
         // Nibble MSB carries the round constant: bit 127 always, bits 23..3 get c5..c0.
         if (gj == 31) begin : g_msb
            assign w_rk[4*gj+3] = 1'b1;
         end else if (gj < 6) begin : g_cst
            assign w_rk[4*gj+3] = w_c[gi+1][gj];
         end else begin : g_zero
            assign w_rk[4*gj+3] = 1'b0;
         end
         assign w_rk[4*gj+2] = w_key[gi][64+gj];
         assign w_rk[4*gj+1] = w_key[gi][gj];
         assign w_rk[4*gj]   = 1'b0;
      end

      for (genvar gj = 0; gj < 128; gj++) begin : g_perm
         assign w_perm[perm_idx(gj)] = w_sub[gj];
      end

      assign w_st[gi+1]  = w_perm ^ w_rk;
      assign w_key[gi+1] = key_upd(w_key[gi]);
   end

   assign w_last = (r_cnt == CW'(ROUNDS));

   always_ff @(posedge inClk) begin
      if (inRst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (inValid) w_state_next = S_RUN;
         S_RUN:   if (w_last)  w_state_next = S_DONE;
         S_DONE:  if (inReady) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      outReady = (r_state == S_IDLE);
      outValid = (r_state == S_DONE);
   end

   always_ff @(posedge inClk) begin
      if (inRst) begin
         r_st       <= '0;
         r_key      <= '0;
         r_c        <= '0;
         r_cnt      <= '0;
         r_out_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (inValid) begin
                  r_st  <= inData;
                  r_key <= inKey;
                  r_c   <= '0;
                  r_cnt <= '0;
               end
            end
            S_RUN: begin
               if (w_last) begin
                  r_out_data <= r_st;
               end else begin
                  r_st  <= w_st[ROUNDS_PER_CYCLE];
                  r_key <= w_key[ROUNDS_PER_CYCLE];
                  r_c   <= w_c[ROUNDS_PER_CYCLE];
                  r_cnt <= r_cnt + CW'(ROUNDS_PER_CYCLE);
               end
            end
            default: ;
         endcase
      end
   end

   assign outData = r_out_data;

endmodule
